// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: recovers RecX/RecY from the HS/VS/BLANK_N stream and tracks lock.
// Optional `VGA_DEC_BLANK_CHECK_EN` also flags VGA_BLANK_N disagreeing with the decoded window.

module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       pix_en,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic       VGA_BLANK_N,
  output logic [9:0] RecX,
  output logic [9:0] RecY,
  output logic       rec_valid,
  output logic       locked,
  output logic       frame_start,
  output logic       err,
  output logic [7:0] frame_count
);

  localparam logic [9:0] CNT_MAX   = 10'h3ff;
  localparam logic [9:0] H_TOT_W   = 10'(H_TOTAL);
  localparam logic [9:0] H_LAST_W  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] H_START_W = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_W   = 10'(H_ACTIVE);
  localparam logic [9:0] V_TOT_W   = 10'(V_TOTAL);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] V_START_W = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_W   = 10'(V_ACTIVE);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state;
  logic       hs_prev;
  logic       vs_prev;
  logic       h_seen;
  logic       h_armed;
  logic       v_seen;
  logic       v_armed;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [7:0] good;

  logic       hs_fall;
  logic       hs_rise;
  logic       vs_fall;
  logic       vs_rise;
  logic [9:0] hcnt_cur;
  logic [9:0] vcnt_inc;
  logic [9:0] vcnt_cur;
  logic [9:0] rec_x_raw;
  logic [9:0] rec_y_raw;
  logic       in_window;
  logic       timing_err;
  logic       blank_err;
  logic       any_err;

`ifdef VGA_DEC_BLANK_CHECK_EN
  assign blank_err = (VGA_BLANK_N != in_window);
`else
  logic blank_unused;
  assign blank_unused = VGA_BLANK_N;
  assign blank_err    = 1'b0;
`endif

  // hcnt_cur/vcnt_cur are the coordinates of the pixel being sampled right now;
  // the length checks look at the registered counts, i.e. the previous pixel.
  always_comb begin
    hs_fall   = hs_prev & ~VGA_HS;
    hs_rise   = ~hs_prev & VGA_HS;
    vs_fall   = vs_prev & ~VGA_VS;
    vs_rise   = ~vs_prev & VGA_VS;
    hcnt_cur  = hs_fall ? 10'd0 : ((hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1);
    vcnt_inc  = (hs_fall && (vcnt != CNT_MAX)) ? vcnt + 10'd1 : vcnt;
    vcnt_cur  = vs_fall ? 10'd0 : vcnt_inc;
    rec_x_raw = hcnt_cur - H_START_W;
    rec_y_raw = vcnt_cur - V_START_W;
    in_window = (rec_x_raw < H_ACT_W) && (rec_y_raw < V_ACT_W);
    timing_err = (hs_fall && h_armed && (hcnt != H_LAST_W))
              || (hs_rise && h_seen && (hcnt_cur != H_SYNC_W))
              || (!hs_fall && h_seen && (hcnt_cur == H_TOT_W))
              || (vs_fall && v_armed && (vcnt_inc != V_TOT_W))
              || (vs_rise && v_seen && (vcnt_cur != V_SYNC_W));
    any_err   = timing_err | blank_err;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= SEARCH;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      h_seen      <= 1'b0;
      h_armed     <= 1'b0;
      v_seen      <= 1'b0;
      v_armed     <= 1'b0;
      hcnt        <= 10'd0;
      vcnt        <= 10'd0;
      good        <= 8'd0;
      RecX        <= 10'd0;
      RecY        <= 10'd0;
      rec_valid   <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      frame_start <= 1'b0;
      err         <= 1'b0;
      if (pix_en) begin
        hs_prev     <= VGA_HS;
        vs_prev     <= VGA_VS;
        hcnt        <= hcnt_cur;
        vcnt        <= vcnt_cur;
        frame_start <= vs_fall;
        err         <= any_err;
        if (hs_fall) h_seen <= 1'b1;
        if (vs_fall) v_seen <= 1'b1;
        if (in_window) begin
          RecX <= rec_x_raw;
          RecY <= rec_y_raw;
        end
        // Armed flags exempt the first line/frame measured after losing lock.
        if (any_err) begin
          state     <= SEARCH;
          locked    <= 1'b0;
          rec_valid <= 1'b0;
          h_armed   <= 1'b0;
          v_armed   <= 1'b0;
        end else begin
          if (hs_fall) h_armed <= 1'b1;
          if (vs_fall) v_armed <= 1'b1;
          rec_valid <= locked & in_window;
          if (vs_fall) begin
            case (state)
              SEARCH: begin
                state <= TRACK;
                good  <= 8'd0;
              end
              TRACK: begin
                good <= good + 8'd1;
                if (good == LOCK_LAST) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  rec_valid <= in_window;
                end
              end
              LOCKED: frame_count <= frame_count + 8'd1;
              default: state <= SEARCH;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder: nominal 800-pixel lines with a short 8-line frame
// so that lock, relock, reset and sync-fault scenarios fit in a modest cycle count.

module tb_vga_sync_decoder;

  localparam int HT  = 800;
  localparam int HSW = 96;
  localparam int HST = 144;
  localparam int HA  = 640;
  localparam int VT  = 8;
  localparam int VSW = 2;
  localparam int VST = 4;
  localparam int VA  = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       VGA_HS = 1'b1;
  logic       VGA_VS = 1'b1;
  logic       VGA_BLANK_N = 1'b0;
  logic [9:0] RecX;
  logic [9:0] RecY;
  logic       rec_valid;
  logic       locked;
  logic       frame_start;
  logic       err;
  logic [7:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int gh = 0;
  int gv = 0;
  int gf = 0;

  vga_sync_decoder #(
    .H_ACTIVE(640), .H_SYNC(96), .H_BACK(48), .H_TOTAL(800),
    .V_ACTIVE(3), .V_SYNC(2), .V_BACK(2), .V_TOTAL(8), .LOCK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .RecX(RecX), .RecY(RecY), .rec_valid(rec_valid), .locked(locked),
    .frame_start(frame_start), .err(err), .frame_count(frame_count)
  );

  always #10 Clk = ~Clk;

  // Drive one pixel, sample 1 ns after the edge, advance the generator position.
  task automatic drive_px(input logic hs, input logic vs, input logic bl);
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_BLANK_N = bl;
    pix_en = 1'b1;
    @(posedge Clk);
    #1;
    pix_en = 1'b0;
    if (gh == HT - 1) begin
      gh = 0;
      if (gv == VT - 1) begin
        gv = 0;
        gf++;
      end else begin
        gv++;
      end
    end else begin
      gh++;
    end
  endtask

  task automatic step_nominal();
    drive_px(gh >= HSW, gv >= VSW,
             (gh >= HST) && (gh < HST + HA) && (gv >= VST) && (gv < VST + VA));
  endtask

  task automatic run_to(input int f, input int v, input int h);
    int n = 0;
    while (!(gf == f && gv == v && gh == h)) begin
      if (n > 60000) begin
        vectors++;
        miscompares++;
        $display("FAIL run_to target f%0d v%0d h%0d not reached, at f%0d v%0d h%0d", f, v, h, gf, gv, gh);
        return;
      end
      step_nominal();
      n++;
    end
  endtask

  task automatic idle(input int n);
    pix_en = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    idle(3);
    vectors++; if (RecX !== 10'd0) begin miscompares++; $display("FAIL reset_recx got=%0d exp=0", RecX); end
    vectors++; if (RecY !== 10'd0) begin miscompares++; $display("FAIL reset_recy got=%0d exp=0", RecY); end
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rec_valid got=%b exp=0", rec_valid); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got=%b exp=0", locked); end
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
    vectors++; if (frame_count !== 8'd0) begin miscompares++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
    @(negedge Clk);
    Reset_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_lock();
    step_nominal();
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL vsfall1_frame_start got=%b exp=1", frame_start); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL vsfall1_err got=%b exp=0", err); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL vsfall1_locked got=%b exp=0", locked); end
    run_to(1, 0, 0);
    step_nominal();
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL vsfall2_locked got=%b exp=0", locked); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL vsfall2_err got=%b exp=0", err); end
    run_to(2, 0, 0);
    step_nominal();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL vsfall3_locked got=%b exp=1", locked); end
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL vsfall3_frame_start got=%b exp=1", frame_start); end
    vectors++; if (frame_count !== 8'd0) begin miscompares++; $display("FAIL vsfall3_frame_count got=%0d exp=0", frame_count); end
    idle(1);
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL idle_frame_start got=%b exp=0", frame_start); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL idle_locked got=%b exp=1", locked); end
    $display("test_lock done");
  endtask

  task automatic test_window();
    run_to(2, 4, 143);
    step_nominal();
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL h143_rec_valid got=%b exp=0", rec_valid); end
    step_nominal();
    vectors++; if (RecX !== 10'd0) begin miscompares++; $display("FAIL first_px_recx got=%0d exp=0", RecX); end
    vectors++; if (RecY !== 10'd0) begin miscompares++; $display("FAIL first_px_recy got=%0d exp=0", RecY); end
    vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL first_px_rec_valid got=%b exp=1", rec_valid); end
    run_to(2, 4, 200);
    step_nominal();
    vectors++; if (RecX !== 10'd56) begin miscompares++; $display("FAIL h200_recx got=%0d exp=56", RecX); end
    idle(3);
    vectors++; if (RecX !== 10'd56) begin miscompares++; $display("FAIL hold_recx got=%0d exp=56", RecX); end
    vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL hold_rec_valid got=%b exp=1", rec_valid); end
    step_nominal();
    vectors++; if (RecX !== 10'd57) begin miscompares++; $display("FAIL h201_recx got=%0d exp=57", RecX); end
    run_to(2, 4, 783);
    step_nominal();
    vectors++; if (RecX !== 10'd639) begin miscompares++; $display("FAIL h783_recx got=%0d exp=639", RecX); end
    vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL h783_rec_valid got=%b exp=1", rec_valid); end
    step_nominal();
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL h784_rec_valid got=%b exp=0", rec_valid); end
    vectors++; if (RecX !== 10'd639) begin miscompares++; $display("FAIL h784_recx_hold got=%0d exp=639", RecX); end
    run_to(2, 6, 144);
    step_nominal();
    vectors++; if (RecY !== 10'd2) begin miscompares++; $display("FAIL last_line_recy got=%0d exp=2", RecY); end
    run_to(2, 7, 144);
    step_nominal();
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL porch_rec_valid got=%b exp=0", rec_valid); end
    vectors++; if (RecY !== 10'd2) begin miscompares++; $display("FAIL porch_recy_hold got=%0d exp=2", RecY); end
    $display("test_window done");
  endtask

  task automatic test_simultaneous_sync();
    run_to(3, 0, 0);
    step_nominal();
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL simul_frame_start got=%b exp=1", frame_start); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL simul_err got=%b exp=0", err); end
    vectors++; if (frame_count !== 8'd1) begin miscompares++; $display("FAIL vsfall4_frame_count got=%0d exp=1", frame_count); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL simul_locked got=%b exp=1", locked); end
    step_nominal();
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL frame_start_pulse got=%b exp=0", frame_start); end
    run_to(3, 4, 144);
    step_nominal();
    vectors++; if (RecY !== 10'd0) begin miscompares++; $display("FAIL restart_recy got=%0d exp=0", RecY); end
    vectors++; if (RecX !== 10'd0) begin miscompares++; $display("FAIL restart_recx got=%0d exp=0", RecX); end
    vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL restart_rec_valid got=%b exp=1", rec_valid); end
    $display("test_simultaneous_sync done");
  endtask

  task automatic test_blank();
    run_to(3, 4, 244);
    drive_px(1'b1, 1'b1, 1'b0);
    vectors++; if (RecX !== 10'd100) begin miscompares++; $display("FAIL blank_recx got=%0d exp=100", RecX); end
`ifdef VGA_DEC_BLANK_CHECK_EN
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL blank_err got=%b exp=1", err); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL blank_locked got=%b exp=0", locked); end
`else
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL blank_err got=%b exp=0", err); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL blank_locked got=%b exp=1", locked); end
`endif
    $display("test_blank done");
  endtask

  task automatic test_short_line();
    run_to(3, 5, 799);
    gh = 0;
    gv = 6;
    step_nominal();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL short_line_err got=%b exp=1", err); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL short_line_locked got=%b exp=0", locked); end
    vectors++; if (frame_count !== 8'd1) begin miscompares++; $display("FAIL short_line_frame_count got=%0d exp=1", frame_count); end
    step_nominal();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL short_line_err_pulse got=%b exp=0", err); end
    run_to(4, 0, 0);
    step_nominal();
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL relock1_locked got=%b exp=0", locked); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL relock1_err got=%b exp=0", err); end
    run_to(5, 0, 0);
    step_nominal();
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL relock2_locked got=%b exp=0", locked); end
    run_to(6, 0, 0);
    step_nominal();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL relock3_locked got=%b exp=1", locked); end
    vectors++; if (frame_count !== 8'd1) begin miscompares++; $display("FAIL relock3_frame_count got=%0d exp=1", frame_count); end
    $display("test_short_line done");
  endtask

  task automatic test_async_reset();
    run_to(6, 6, 200);
    step_nominal();
    vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL prereset_rec_valid got=%b exp=1", rec_valid); end
    vectors++; if (RecY !== 10'd2) begin miscompares++; $display("FAIL prereset_recy got=%0d exp=2", RecY); end
    #5;
    Reset_n = 1'b0;
    #1;
    vectors++; if (RecX !== 10'd0) begin miscompares++; $display("FAIL areset_recx got=%0d exp=0", RecX); end
    vectors++; if (RecY !== 10'd0) begin miscompares++; $display("FAIL areset_recy got=%0d exp=0", RecY); end
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL areset_rec_valid got=%b exp=0", rec_valid); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL areset_locked got=%b exp=0", locked); end
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL areset_frame_start got=%b exp=0", frame_start); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL areset_err got=%b exp=0", err); end
    vectors++; if (frame_count !== 8'd0) begin miscompares++; $display("FAIL areset_frame_count got=%0d exp=0", frame_count); end
    run_to(6, 7, 0);
    vectors++; if (RecX !== 10'd0) begin miscompares++; $display("FAIL held_reset_recx got=%0d exp=0", RecX); end
    Reset_n = 1'b1;
    $display("test_async_reset done");
  endtask

  task automatic test_hs_stretch();
    run_to(7, 0, 0);
    step_nominal();
    vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL post_reset_frame_start got=%b exp=1", frame_start); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL post_reset_err got=%b exp=0", err); end
    run_to(7, 0, 96);
    drive_px(1'b0, 1'b0, 1'b0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL stretch_h96_err got=%b exp=0", err); end
    step_nominal();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL stretch_rise_err got=%b exp=1", err); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL stretch_locked got=%b exp=0", locked); end
    step_nominal();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL stretch_err_pulse got=%b exp=0", err); end
    $display("test_hs_stretch done");
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout at f%0d v%0d h%0d", gf, gv, gh);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_window();
    test_simultaneous_sync();
    test_blank();
    test_short_line();
    test_async_reset();
    test_hs_stretch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

- Receive-side counterpart of `VGA_controller`: observes the `VGA_HS`/`VGA_VS`/`VGA_BLANK_N` stream it emits and recovers pixel coordinates.
- Checks the timing against the 640x480@60 template and reports lock and errors.
- Sits beside the display path in `toplevel` as an on-chip monitor. It also serves as the raster reference for the planned light-gun hit detector, which needs beam position independent of the generator's `DrawX`/`DrawY`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_SYNC`, 96, HS low width in pixels
- `H_BACK`, 48, back porch in pixels
- `H_TOTAL`, 800, pixels per line
- `V_ACTIVE`, 480, visible lines
- `V_SYNC`, 2, VS low width in lines
- `V_BACK`, 33, back porch in lines
- `V_TOTAL`, 525, lines per frame
- `LOCK_FRAMES`, 2, consecutive good frames required to assert lock

Ports:
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `pix_en` in 1: one-`Clk` strobe per pixel. Inputs are sampled only when it is high.
- `VGA_HS` in 1: horizontal sync, active low.
- `VGA_VS` in 1: vertical sync, active low.
- `VGA_BLANK_N` in 1: active-video flag.
- `RecX` out 10: recovered column, 0..H_ACTIVE-1.
- `RecY` out 10: recovered row, 0..V_ACTIVE-1.
- `rec_valid` out 1: locked and the current pixel is in the active window.
- `locked` out 1: timing lock established.
- `frame_start` out 1: one-`Clk` pulse on each VS falling edge.
- `err` out 1: one-`Clk` pulse on any timing violation.
- `frame_count` out 8: count of good frames, wraps at 255.

## Operation
- Internal 10-bit `hcnt` and `vcnt` are cleared by sync falling edges.
- Edges are detected against the previous sample, and only on `pix_en` cycles.
- `hcnt`:
  - HS fall sets `hcnt` to 0; otherwise `hcnt` increments on each `pix_en`.
  - `hcnt` saturates at 1023.
  - HS fall increments `vcnt`; VS fall sets `vcnt` to 0.
- Horizontal checks:
  - At HS fall, a line length (`hcnt`+1) different from `H_TOTAL` is an error.
  - The first line after SEARCH is exempt.
  - At HS rise, an `hcnt` different from `H_SYNC` is an error.
  - `hcnt` reaching `H_TOTAL` with no HS fall is an error.
- Vertical checks:
  - At VS fall, a line count different from `V_TOTAL` is an error.
  - The first frame after SEARCH is exempt.
  - At VS rise, a `vcnt` different from `V_SYNC` is an error.
- Simultaneous HS and VS falls on the same pixel:
  - The HS update is applied first, then the VS check uses the incremented `vcnt`, then `vcnt` is set to 0.
- Coordinates:
  - `RecX` = `hcnt` − (`H_SYNC`+`H_BACK`).
  - `RecY` = `vcnt` − (`V_SYNC`+`V_BACK`).
  - Both are computed as 10-bit unsigned values.
  - Active window: 0 ≤ `RecX` < `H_ACTIVE` and 0 ≤ `RecY` < `V_ACTIVE`.
  - Outside the window, `RecX`/`RecY` hold their last active values.
- FSM:
  - SEARCH → TRACK on the first VS fall. `good` is cleared.
  - In TRACK, each error-free VS fall increments `good`. At `good` = `LOCK_FRAMES`, go to LOCKED.
  - In LOCKED, each error-free VS fall increments `frame_count`.
  - Any error in TRACK or LOCKED → SEARCH, `locked` deasserts, `frame_count` is held.
  - An error in SEARCH pulses `err` and stays in SEARCH.
- `rec_valid` = `locked` AND active window.

## Timing
- All outputs are registered.
- They update on the `Clk` edge where `pix_en` is high, one cycle after the sampled pixel.
- With `pix_en` low, all state and outputs hold, except that `frame_start` and `err` return to 0.
- Async reset mid-operation:
  - Returns the FSM to SEARCH immediately and clears every output to 0.
  - Previous sync samples reset to 1, the idle level.
- Reset values: `RecX`=0, `RecY`=0, `rec_valid`=0, `locked`=0, `frame_start`=0, `err`=0, `frame_count`=0.
- `locked` asserts in the cycle after the VS-fall sample that completes good frame `LOCK_FRAMES`.
- `err` and `frame_start` may pulse in the same cycle.

## Configuration
- `VGA_DEC_BLANK_CHECK_EN`
  - Defined: `VGA_BLANK_N` must equal the decoded active window on every `pix_en` sample. A mismatch is an error, with the same consequences as the timing errors above.
  - Undefined: `VGA_BLANK_N` is ignored and the window is purely computed.

## Test plan
- Drive 3 nominal 800x525 frames from a reference generator.
  - `locked` rises after the 3rd VS fall (1 to enter TRACK + 2 good).
  - `frame_count`=1 after the 4th VS fall.
- Check the first active pixel.
  - At `hcnt`=144, `vcnt`=35: `RecX`=0, `RecY`=0, `rec_valid`=1.
  - At `hcnt`=783: `RecX`=639.
- While locked, shorten one line to 799 pixels.
  - `err` pulses at that HS fall.
  - `locked`=0.
  - Relock after 3 further clean VS falls.
- Stretch HS low to 97 pixels.
  - `err` pulses at the HS rise; state goes to SEARCH.
- Assert HS and VS falls on the same pixel at line 525 with nominal timing.
  - No `err`; `frame_start`=1.
  - `RecY` restarts correctly.
- Pull `Reset_n` low mid-frame while locked.
  - All outputs go to 0 without waiting for a clock edge.
- With `VGA_DEC_BLANK_CHECK_EN` defined, force `VGA_BLANK_N`=0 at `RecX`=100.
  - `err`=1 and `locked`=0.
  - Without the macro: no error.
